// File: rtl/bcrypt_sequencer.sv
// Master sequencer for the bcrypt datapath: EksBlowfishSetup expands, 64x ciphertext encryption, UART handoff.
// Optional abort input enabled by defining BCRYPT_SEQ_ABORT_EN.
module bcrypt_sequencer #(
    parameter int unsigned ROUNDS    = 16,
    parameter int unsigned ROUND_CYC = 2,
    parameter int unsigned P_BLOCKS  = 9,
    parameter int unsigned S_BLOCKS  = 512,
    parameter int unsigned CT_REPS   = 64
) (
    input  logic       clk_0,
    input  logic       reset_l,
    input  logic       start,
`ifdef BCRYPT_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic [4:0] cost,
    output logic       busy,
    output logic       done,
    output logic       cost_err,
    output logic       p_xor_en,
    output logic       salt_key_sel,
    output logic       salt_xor_en,
    output logic       salt_half,
    output logic       round_en,
    output logic [8:0] psel,
    output logic [3:0] sram_we,
    output logic [6:0] sram_waddr,
    output logic       ct_load,
    output logic       ct_shift,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] tx_word_sel
);

    localparam int unsigned NBLK  = P_BLOCKS + S_BLOCKS;
    localparam int unsigned BLK_W = $clog2(NBLK + 1);
    localparam int unsigned SUB_W = $clog2(ROUND_CYC + 1);
    localparam int unsigned RND_W = $clog2(ROUNDS + 1);
    localparam int unsigned REP_W = $clog2(CT_REPS + 1);
    localparam int unsigned SQ    = S_BLOCKS / 4;

    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NBLK - 1);
    localparam logic [BLK_W-1:0] P_NUM    = BLK_W'(P_BLOCKS);
    localparam logic [BLK_W-1:0] SQ_B     = BLK_W'(SQ);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ROUND_CYC - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(CT_REPS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PXOR, S_BLK_PRE, S_ROUND, S_BLK_WB,
        S_CT_PRE, S_CT_ROUND, S_CT_WB, S_TX, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_EKS_SALT, PH_EXP_KEY, PH_EXP_SALT, PH_CTEXT
    } phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [31:0]      iter_q, iter_d;
    logic [4:0]       cost_q, cost_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [1:0]       ctb_q, ctb_d;

    logic       busy_q, busy_d, done_q, done_d, cost_err_q, cost_err_d;
    logic       p_xor_en_q, p_xor_en_d, salt_key_sel_q, salt_key_sel_d;
    logic       salt_xor_en_q, salt_xor_en_d, salt_half_q, salt_half_d;
    logic       round_en_q, round_en_d, ct_load_q, ct_load_d, ct_shift_q, ct_shift_d;
    logic       tx_valid_q, tx_valid_d;
    logic [8:0] psel_q, psel_d;
    logic [3:0] sram_we_q, sram_we_d;
    logic [6:0] sram_waddr_q, sram_waddr_d;
    logic [2:0] tx_word_sel_q, tx_word_sel_d;

    logic [BLK_W-1:0] s_idx;
    logic [31:0]      iter_lim;
    logic             round_last;

    // Next state, counters and the outputs that belong to the next state.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        iter_d   = iter_q;
        cost_d   = cost_q;
        blk_d    = blk_q;
        sub_d    = sub_q;
        rnd_d    = rnd_q;
        rep_d    = rep_q;
        ctb_d    = ctb_q;
        done_d         = 1'b0;
        cost_err_d     = 1'b0;
        p_xor_en_d     = 1'b0;
        salt_key_sel_d = 1'b0;
        salt_xor_en_d  = 1'b0;
        salt_half_d    = 1'b0;
        round_en_d     = 1'b0;
        psel_d         = '0;
        sram_we_d      = '0;
        sram_waddr_d   = '0;
        ct_load_d      = 1'b0;
        ct_shift_d     = 1'b0;
        tx_valid_d     = 1'b0;
        tx_word_sel_d  = '0;
        s_idx      = blk_q - P_NUM;
        iter_lim   = (32'd1 << cost_q) - 32'd1;
        round_last = (sub_q == SUB_LAST) && (rnd_q == RND_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cost >= 5'd4) begin
                        state_d    = S_PXOR;
                        phase_d    = PH_EKS_SALT;
                        iter_d     = '0;
                        cost_d     = cost;
                        p_xor_en_d = 1'b1;
                    end else begin
                        cost_err_d = 1'b1;
                    end
                end
            end
            S_PXOR: begin
                state_d       = S_BLK_PRE;
                blk_d         = '0;
                salt_xor_en_d = (phase_q == PH_EKS_SALT);
            end
            S_BLK_PRE, S_CT_PRE: begin
                state_d    = (state_q == S_BLK_PRE) ? S_ROUND : S_CT_ROUND;
                sub_d      = '0;
                rnd_d      = '0;
                round_en_d = (SUB_LAST == SUB_W'(0));
            end
            S_ROUND, S_CT_ROUND: begin
                if (round_last) begin
                    if (state_q == S_CT_ROUND) begin
                        state_d    = S_CT_WB;
                        ct_shift_d = 1'b1;
                    end else begin
                        state_d = S_BLK_WB;
                        if (blk_q < P_NUM) begin
                            psel_d = 9'(1) << blk_q;
                        end else begin
                            sram_we_d    = 4'(1) << (s_idx / SQ_B);
                            sram_waddr_d = 7'(s_idx % SQ_B);
                        end
                    end
                end else begin
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        rnd_d = rnd_q + RND_W'(1);
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                    round_en_d = (sub_d == SUB_LAST);
                end
            end
            S_BLK_WB: begin
                if (blk_q != BLK_LAST) begin
                    state_d       = S_BLK_PRE;
                    blk_d         = blk_q + BLK_W'(1);
                    salt_xor_en_d = (phase_q == PH_EKS_SALT);
                    salt_half_d   = blk_d[0];
                end else begin
                    case (phase_q)
                        PH_EKS_SALT: begin
                            phase_d    = PH_EXP_KEY;
                            state_d    = S_PXOR;
                            p_xor_en_d = 1'b1;
                        end
                        PH_EXP_KEY: begin
                            phase_d        = PH_EXP_SALT;
                            state_d        = S_PXOR;
                            p_xor_en_d     = 1'b1;
                            salt_key_sel_d = 1'b1;
                        end
                        default: begin
                            if (iter_q == iter_lim) begin
                                phase_d   = PH_CTEXT;
                                state_d   = S_CT_PRE;
                                rep_d     = '0;
                                ctb_d     = '0;
                                ct_load_d = 1'b1;
                            end else begin
                                iter_d     = iter_q + 32'd1;
                                phase_d    = PH_EXP_KEY;
                                state_d    = S_PXOR;
                                p_xor_en_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_CT_WB: begin
                state_d   = S_CT_PRE;
                ct_load_d = 1'b1;
                if (ctb_q == 2'd2) begin
                    ctb_d = '0;
                    if (rep_q == REP_LAST) begin
                        state_d    = S_TX;
                        ct_load_d  = 1'b0;
                        tx_valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end else begin
                    ctb_d = ctb_q + 2'd1;
                end
            end
            S_TX: begin
                // The word index holds until the UART takes it.
                if (tx_ready && (tx_word_sel_q == 3'd5)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    tx_valid_d    = 1'b1;
                    tx_word_sel_d = tx_ready ? tx_word_sel_q + 3'd1 : tx_word_sel_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef BCRYPT_SEQ_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            done_d         = 1'b0;
            p_xor_en_d     = 1'b0;
            salt_key_sel_d = 1'b0;
            salt_xor_en_d  = 1'b0;
            salt_half_d    = 1'b0;
            round_en_d     = 1'b0;
            psel_d         = '0;
            sram_we_d      = '0;
            sram_waddr_d   = '0;
            ct_load_d      = 1'b0;
            ct_shift_d     = 1'b0;
            tx_valid_d     = 1'b0;
            tx_word_sel_d  = '0;
        end
`endif

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk_0 or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= S_IDLE;
            phase_q        <= PH_EKS_SALT;
            iter_q         <= '0;
            cost_q         <= '0;
            blk_q          <= '0;
            sub_q          <= '0;
            rnd_q          <= '0;
            rep_q          <= '0;
            ctb_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cost_err_q     <= 1'b0;
            p_xor_en_q     <= 1'b0;
            salt_key_sel_q <= 1'b0;
            salt_xor_en_q  <= 1'b0;
            salt_half_q    <= 1'b0;
            round_en_q     <= 1'b0;
            psel_q         <= '0;
            sram_we_q      <= '0;
            sram_waddr_q   <= '0;
            ct_load_q      <= 1'b0;
            ct_shift_q     <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_word_sel_q  <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            iter_q         <= iter_d;
            cost_q         <= cost_d;
            blk_q          <= blk_d;
            sub_q          <= sub_d;
            rnd_q          <= rnd_d;
            rep_q          <= rep_d;
            ctb_q          <= ctb_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cost_err_q     <= cost_err_d;
            p_xor_en_q     <= p_xor_en_d;
            salt_key_sel_q <= salt_key_sel_d;
            salt_xor_en_q  <= salt_xor_en_d;
            salt_half_q    <= salt_half_d;
            round_en_q     <= round_en_d;
            psel_q         <= psel_d;
            sram_we_q      <= sram_we_d;
            sram_waddr_q   <= sram_waddr_d;
            ct_load_q      <= ct_load_d;
            ct_shift_q     <= ct_shift_d;
            tx_valid_q     <= tx_valid_d;
            tx_word_sel_q  <= tx_word_sel_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cost_err     = cost_err_q;
    assign p_xor_en     = p_xor_en_q;
    assign salt_key_sel = salt_key_sel_q;
    assign salt_xor_en  = salt_xor_en_q;
    assign salt_half    = salt_half_q;
    assign round_en     = round_en_q;
    assign psel         = psel_q;
    assign sram_we      = sram_we_q;
    assign sram_waddr   = sram_waddr_q;
    assign ct_load      = ct_load_q;
    assign ct_shift     = ct_shift_q;
    assign tx_valid     = tx_valid_q;
    assign tx_word_sel  = tx_word_sel_q;

endmodule

// File: tb/tb_bcrypt_sequencer.sv
// Directed bench for bcrypt_sequencer with reduced block sizes (ROUNDS=2, ROUND_CYC=1, S_BLOCKS=4, CT_REPS=2).
`timescale 1ns/1ps
module tb_bcrypt_sequencer;

    localparam int unsigned ROUNDS    = 2;
    localparam int unsigned ROUND_CYC = 1;
    localparam int unsigned P_BLOCKS  = 9;
    localparam int unsigned S_BLOCKS  = 4;
    localparam int unsigned CT_REPS   = 2;
    localparam int BLK    = 2 + ROUNDS * ROUND_CYC;           // 4
    localparam int EXPAND = 1 + (P_BLOCKS + S_BLOCKS) * BLK;  // 53
    localparam int N_EXP  = 1 + 2 * 16;                       // cost 4
    localparam int T_TX   = 1 + N_EXP * EXPAND + CT_REPS * 3 * BLK;  // 1774
    localparam int T_DONE = T_TX + 6;
    localparam int BUDGET = 4000;

    logic       clk_0 = 1'b0;
    logic       reset_l, start, tx_ready;
    logic [4:0] cost;
`ifdef BCRYPT_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       busy, done, cost_err, p_xor_en, salt_key_sel, salt_xor_en, salt_half, round_en;
    logic [8:0] psel;
    logic [3:0] sram_we;
    logic [6:0] sram_waddr;
    logic       ct_load, ct_shift, tx_valid;
    logic [2:0] tx_word_sel;
    logic [33:0] all_out;

    assign all_out = {busy, done, cost_err, p_xor_en, salt_key_sel, salt_xor_en, salt_half, round_en,
                      psel, sram_we, sram_waddr, ct_load, ct_shift, tx_valid, tx_word_sel};

    always #5 clk_0 = ~clk_0;

    bcrypt_sequencer #(
        .ROUNDS(ROUNDS), .ROUND_CYC(ROUND_CYC), .P_BLOCKS(P_BLOCKS),
        .S_BLOCKS(S_BLOCKS), .CT_REPS(CT_REPS)
    ) dut (
        .clk_0(clk_0), .reset_l(reset_l), .start(start),
`ifdef BCRYPT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .cost(cost), .busy(busy), .done(done), .cost_err(cost_err),
        .p_xor_en(p_xor_en), .salt_key_sel(salt_key_sel), .salt_xor_en(salt_xor_en),
        .salt_half(salt_half), .round_en(round_en), .psel(psel), .sram_we(sram_we),
        .sram_waddr(sram_waddr), .ct_load(ct_load), .ct_shift(ct_shift),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_word_sel(tx_word_sel)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_tx, done_cyc;
    int n_pxor, n_ksel, n_sxor, n_round, n_ctl, n_cts;
    int n_psel[9];
    int n_we[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
        cyc++;
    endtask

    task automatic start_run(input logic [4:0] c);
        n_pxor = 0; n_ksel = 0; n_sxor = 0; n_round = 0; n_ctl = 0; n_cts = 0;
        for (int i = 0; i < 9; i++) n_psel[i] = 0;
        for (int i = 0; i < 4; i++) n_we[i] = 0;
        @(negedge clk_0);
        start = 1'b1;
        cost  = c;
        @(posedge clk_0);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    // Per-cycle bookkeeping during a run: strobe tallies, exclusivity and busy.
    task automatic sample();
        int n;
        n = int'(p_xor_en) + int'(salt_xor_en) + int'(round_en) + int'(|psel) + int'(|sram_we)
          + int'(ct_load) + int'(ct_shift) + int'(tx_valid) + int'(done) + int'(cost_err);
        chk("strobe_excl", 64'((n <= 1) && ($countones(psel) <= 1) && ($countones(sram_we) <= 1)), 64'(1));
        chk("busy_in_run", 64'(busy), 64'(!done));
        n_pxor  += int'(p_xor_en);
        n_ksel  += int'(salt_key_sel);
        n_sxor  += int'(salt_xor_en);
        n_round += int'(round_en);
        n_ctl   += int'(ct_load);
        n_cts   += int'(ct_shift);
        for (int i = 0; i < 9; i++) n_psel[i] += int'(psel[i]);
        for (int i = 0; i < 4; i++) n_we[i] += int'(sram_we[i]);
    endtask

    initial begin
        reset_l  = 1'b0;
        start    = 1'b0;
        cost     = 5'd0;
        tx_ready = 1'b0;
`ifdef BCRYPT_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) @(posedge clk_0);
        #1;
        chk("reset_outputs", 64'(all_out), 64'(0));
        @(negedge clk_0);
        reset_l = 1'b1;
        tick();
        chk("idle_outputs", 64'(all_out), 64'(0));

        // cost below 4 is rejected with a single pulse
        start_run(5'd3);
        chk("cost_err_pulse", 64'(cost_err), 64'(1));
        chk("cost_err_busy", 64'(busy), 64'(0));
        tick();
        chk("cost_err_clear", 64'(all_out), 64'(0));

        // run aborted by reset_l at cycle 500
        start_run(5'd4);
        while (cyc < 500) tick();
        chk("busy_before_rst", 64'(busy), 64'(1));
        reset_l = 1'b0;
        #1;
        chk("async_rst_outputs", 64'(all_out), 64'(0));
        @(negedge clk_0);
        reset_l = 1'b1;
        tick();

        // full run, tx_ready held high, stray start at cycle 100
        tx_ready = 1'b1;
        start_run(5'd4);
        sample();
        chk("c1_pxor", 64'(p_xor_en), 64'(1));
        chk("c1_ksel", 64'(salt_key_sel), 64'(0));
        tick(); sample();
        chk("c2_salt_xor", 64'({salt_xor_en, salt_half}), 64'(2));
        tick(); sample();
        chk("c3_round_en", 64'(round_en), 64'(1));
        tick(); sample();
        chk("c4_round_en", 64'(round_en), 64'(1));
        tick(); sample();
        chk("c5_psel0", 64'(psel), 64'(9'h001));
        tick(); sample();
        chk("c6_salt_half1", 64'({salt_xor_en, salt_half}), 64'(3));
        first_tx = 0;
        done_cyc = 0;
        while (!done && cyc < BUDGET) begin
            start = (cyc == 100);
            tick(); sample();
            if (tx_valid) begin
                if (first_tx == 0) first_tx = cyc;
                chk("tx_sel_seq", 64'(tx_word_sel), 64'(cyc - first_tx));
            end
        end
        start = 1'b0;
        done_cyc = cyc;
        chk("run_done_seen", 64'(done), 64'(1));
        chk("first_tx_cycle", 64'(first_tx), 64'(T_TX));
        chk("done_cycle", 64'(done_cyc), 64'(T_DONE));
        chk("cnt_pxor", 64'(n_pxor), 64'(33));
        chk("cnt_ksel", 64'(n_ksel), 64'(16));
        chk("cnt_salt_xor", 64'(n_sxor), 64'(13));
        chk("cnt_round_en", 64'(n_round), 64'(33 * 13 * 2 + 6 * 2));
        chk("cnt_ct_load", 64'(n_ctl), 64'(6));
        chk("cnt_ct_shift", 64'(n_cts), 64'(6));
        for (int i = 0; i < 9; i++) chk("cnt_psel_bit", 64'(n_psel[i]), 64'(33));
        for (int i = 0; i < 4; i++) chk("cnt_sram_we_bit", 64'(n_we[i]), 64'(33));
        tick();
        chk("post_done_idle", 64'(all_out), 64'(0));

        // tx back-pressure: stall 10 cycles on word 2
        tx_ready = 1'b0;
        start_run(5'd4);
        while (!tx_valid && cyc < BUDGET) tick();
        chk("stall_first_tx", 64'(cyc), 64'(T_TX));
        chk("stall_sel0", 64'(tx_word_sel), 64'(0));
        tx_ready = 1'b1;
        tick();
        chk("stall_sel1", 64'(tx_word_sel), 64'(1));
        tick();
        chk("stall_sel2", 64'(tx_word_sel), 64'(2));
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_hold", 64'({tx_valid, tx_word_sel}), 64'({1'b1, 3'd2}));
            chk("stall_quiet", 64'({done, p_xor_en, salt_xor_en, round_en, psel, sram_we, ct_load, ct_shift}), 64'(0));
        end
        tx_ready = 1'b1;
        tick();
        chk("stall_sel3", 64'(tx_word_sel), 64'(3));
        tick();
        tick();
        chk("stall_sel5", 64'(tx_word_sel), 64'(5));
        tick();
        chk("stall_done", 64'({done, busy, tx_valid}), 64'(3'b100));
        chk("stall_done_cycle", 64'(cyc), 64'(T_TX + 16));
        tick();
        chk("stall_idle", 64'(all_out), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
